// File: rtl/cache_bus_axi_bridge_pkg.sv
// Shared cache-bus types plus the AXI encodings and bridge state used by the bus bridge.
package cache_bus_axi_bridge_pkg;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [3:0]  burst_size;
    logic        cached;
    logic [1:0]  data_size;
    logic [31:0] addr;
    logic        data_ok;
    logic        data_last;
    logic [3:0]  data_strobe;
    logic [31:0] w_data;
  } cache_bus_req_t;

  typedef struct packed {
    logic        ready;
    logic        data_ok;
    logic        data_last;
    logic [31:0] r_data;
  } cache_bus_resp_t;

  localparam logic [1:0] AXI_BURST_INCR      = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY       = 2'b00;
  localparam logic [3:0] CACHED_ATTR_DEFAULT = 4'b1111;

  typedef enum logic [5:0] {
    IDLE  = 6'b000001,
    RADDR = 6'b000010,
    RDATA = 6'b000100,
    WADDR = 6'b001000,
    WDATA = 6'b010000,
    WRESP = 6'b100000
  } bridge_state_e;

endpackage

// File: rtl/cache_bus_axi_bridge.sv
// Cache-bus responder that turns each accepted request into one AXI4 INCR burst.
module cache_bus_axi_bridge
  import cache_bus_axi_bridge_pkg::*;
#(
  parameter int unsigned         ID_WIDTH    = 4,
  parameter logic [ID_WIDTH-1:0] ID_VALUE    = '0,
  parameter logic [3:0]          CACHED_ATTR = CACHED_ATTR_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  cache_bus_req_t      bus_req_i,
  output cache_bus_resp_t     bus_resp_o,
  output logic                err_o,
  output logic                arvalid_o,
  input  logic                arready_i,
  output logic [31:0]         araddr_o,
  output logic [7:0]          arlen_o,
  output logic [2:0]          arsize_o,
  output logic [1:0]          arburst_o,
  output logic [3:0]          arcache_o,
  output logic [ID_WIDTH-1:0] arid_o,
  input  logic                rvalid_i,
  output logic                rready_o,
  input  logic [31:0]         rdata_i,
  input  logic                rlast_i,
  input  logic [1:0]          rresp_i,
  input  logic [ID_WIDTH-1:0] rid_i,
  output logic                awvalid_o,
  input  logic                awready_i,
  output logic [31:0]         awaddr_o,
  output logic [7:0]          awlen_o,
  output logic [2:0]          awsize_o,
  output logic [1:0]          awburst_o,
  output logic [3:0]          awcache_o,
  output logic [ID_WIDTH-1:0] awid_o,
  output logic                wvalid_o,
  input  logic                wready_i,
  output logic [31:0]         wdata_o,
  output logic [3:0]          wstrb_o,
  output logic                wlast_o,
  input  logic                bvalid_i,
  output logic                bready_o,
  input  logic [1:0]          bresp_i
);

  bridge_state_e state_q, state_d;
  logic [31:0]   addr_q;
  logic [7:0]    len_q;
  logic [7:0]    beat_q;
  logic [2:0]    size_q;
  logic [3:0]    cache_q;
  logic          err_q;
  logic          r_hs, w_hs, b_hs, wlast;
  logic          unused_rid;

  assign unused_rid = ^rid_i;

  assign r_hs  = (state_q == RDATA) && rvalid_i && bus_req_i.data_ok;
  assign w_hs  = (state_q == WDATA) && wready_i && bus_req_i.data_ok;
  assign b_hs  = (state_q == WRESP) && bvalid_i;
  assign wlast = (state_q == WDATA) && (beat_q == len_q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Request latch, write beat counter and sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      cache_q <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && bus_req_i.valid) begin
        addr_q  <= bus_req_i.addr;
        len_q   <= {4'b0000, bus_req_i.burst_size};
        size_q  <= {1'b0, bus_req_i.data_size};
        cache_q <= bus_req_i.cached ? CACHED_ATTR : 4'b0000;
      end
      if (state_q == WADDR && awready_i) beat_q <= '0;
      else if (w_hs)                     beat_q <= beat_q + 8'd1;
      if ((w_hs && (bus_req_i.data_last != wlast)) ||
          (r_hs && (rresp_i != AXI_RESP_OKAY)) ||
          (b_hs && (bresp_i != AXI_RESP_OKAY)))
        err_q <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus_req_i.valid) state_d = bus_req_i.write ? WADDR : RADDR;
      RADDR:   if (arready_i) state_d = RDATA;
      RDATA:   if (r_hs && rlast_i) state_d = IDLE;
      WADDR:   if (awready_i) state_d = WDATA;
      WDATA:   if (w_hs && wlast) state_d = WRESP;
      WRESP:   if (bvalid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Cache-bus response; ready is masked by rst so nothing is accepted while reset is asserted
  always_comb begin
    bus_resp_o       = '0;
    bus_resp_o.ready = (state_q == IDLE) && !rst;
    if (state_q == RDATA) begin
      bus_resp_o.data_ok   = r_hs;
      bus_resp_o.data_last = rlast_i;
      bus_resp_o.r_data    = rdata_i;
    end else if (state_q == WDATA) begin
      bus_resp_o.data_ok = w_hs;
    end
  end

  assign arvalid_o = (state_q == RADDR);
  assign araddr_o  = addr_q;
  assign arlen_o   = len_q;
  assign arsize_o  = size_q;
  assign arburst_o = AXI_BURST_INCR;
  assign arcache_o = cache_q;
  assign arid_o    = ID_VALUE;

  assign rready_o  = (state_q == RDATA) && bus_req_i.data_ok;

  assign awvalid_o = (state_q == WADDR);
  assign awaddr_o  = addr_q;
  assign awlen_o   = len_q;
  assign awsize_o  = size_q;
  assign awburst_o = AXI_BURST_INCR;
  assign awcache_o = cache_q;
  assign awid_o    = ID_VALUE;

  assign wvalid_o  = (state_q == WDATA) && bus_req_i.data_ok;
  assign wdata_o   = bus_req_i.w_data;
  assign wstrb_o   = bus_req_i.data_strobe;
  assign wlast_o   = wlast;

  assign bready_o  = (state_q == WRESP);

  assign err_o     = err_q;

endmodule

// File: tb/tb_cache_bus_axi_bridge.sv
// Self-checking bench: directed vector table plus randomized transactions against a transaction-level model.
module tb_cache_bus_axi_bridge;
  import cache_bus_axi_bridge_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  cache_bus_req_t  req;
  cache_bus_resp_t resp;
  logic            err;
  logic            arvalid_o, arready_i;
  logic [31:0]     araddr_o;
  logic [7:0]      arlen_o;
  logic [2:0]      arsize_o;
  logic [1:0]      arburst_o;
  logic [3:0]      arcache_o;
  logic [3:0]      arid_o;
  logic            rvalid_i, rready_o, rlast_i;
  logic [31:0]     rdata_i;
  logic [1:0]      rresp_i;
  logic [3:0]      rid_i;
  logic            awvalid_o, awready_i;
  logic [31:0]     awaddr_o;
  logic [7:0]      awlen_o;
  logic [2:0]      awsize_o;
  logic [1:0]      awburst_o;
  logic [3:0]      awcache_o;
  logic [3:0]      awid_o;
  logic            wvalid_o, wready_i, wlast_o;
  logic [31:0]     wdata_o;
  logic [3:0]      wstrb_o;
  logic            bvalid_i, bready_o;
  logic [1:0]      bresp_i;

  cache_bus_axi_bridge #(.ID_WIDTH(4), .ID_VALUE(4'd0), .CACHED_ATTR(4'b1111)) dut (
    .clk(clk), .rst(rst), .bus_req_i(req), .bus_resp_o(resp), .err_o(err),
    .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o), .arlen_o(arlen_o),
    .arsize_o(arsize_o), .arburst_o(arburst_o), .arcache_o(arcache_o), .arid_o(arid_o),
    .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i), .rlast_i(rlast_i),
    .rresp_i(rresp_i), .rid_i(rid_i),
    .awvalid_o(awvalid_o), .awready_i(awready_i), .awaddr_o(awaddr_o), .awlen_o(awlen_o),
    .awsize_o(awsize_o), .awburst_o(awburst_o), .awcache_o(awcache_o), .awid_o(awid_o),
    .wvalid_o(wvalid_o), .wready_i(wready_i), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
    .wlast_o(wlast_o), .bvalid_i(bvalid_i), .bready_o(bready_o), .bresp_i(bresp_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  bsize;
    bit          cached;
    logic [1:0]  dsize;
    int          ar_delay;
    int          hold_at;
    int          hold_len;
    bit          bad_last;
    bit          rnd;
    int          rerr_beat;
    bit          berr;
    int          rst_at_beat;
    logic [7:0]  exp_len;
    logic [2:0]  exp_size;
    logic [3:0]  exp_cache;
  } vec_t;

  vec_t tbl[8];
  int   errors = 0;
  int   checks = 0;
  bit   model_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all_idle(input string tag);
    chk({tag, "_resp"}, 32'(resp), 32'h0);
    chk({tag, "_arvalid"}, arvalid_o, 1'b0);
    chk({tag, "_awvalid"}, awvalid_o, 1'b0);
    chk({tag, "_wvalid"}, wvalid_o, 1'b0);
    chk({tag, "_rready"}, rready_o, 1'b0);
    chk({tag, "_bready"}, bready_o, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk_all_idle("rst");
    step();
    rst = 1'b0;
    model_err = 1'b0;
    step();
  endtask

  // Expected address-phase fields come straight from the request rules.
  function automatic vec_t mk_rand();
    vec_t v;
    v.wr          = 1'($urandom);
    v.addr        = $urandom & 32'hFFFF_FFFC;
    v.bsize       = 4'($urandom);
    v.cached      = 1'($urandom);
    v.dsize       = 2'($urandom_range(0, 2));
    v.ar_delay    = 0;
    v.hold_at     = -1;
    v.hold_len    = 0;
    v.bad_last    = v.wr && ($urandom_range(0, 5) == 0);
    v.rnd         = 1'b1;
    v.rerr_beat   = (!v.wr && $urandom_range(0, 5) == 0) ? int'($urandom_range(0, int'(v.bsize))) : -1;
    v.berr        = v.wr && ($urandom_range(0, 5) == 0);
    v.rst_at_beat = -1;
    v.exp_len     = 8'(v.bsize);
    v.exp_size    = 3'(v.dsize);
    v.exp_cache   = v.cached ? 4'b1111 : 4'b0000;
    return v;
  endfunction

  task automatic run_txn(input vec_t v);
    int          nb, beat, cyc, hold;
    bit          done, av, rdy, dok, hs;
    logic [31:0] d[16];
    logic [3:0]  stb;
    nb = int'(v.exp_len) + 1;
    for (int i = 0; i < 16; i++)
      d[i] = v.rnd ? $urandom : ((v.wr ? 32'hD000_0000 : 32'h0000_00A0) + 32'(i));

    chk("idle_ready", resp.ready, 1'b1);
    req.valid      = 1'b1;
    req.write      = v.wr;
    req.addr       = v.addr;
    req.burst_size = v.bsize;
    req.cached     = v.cached;
    req.data_size  = v.dsize;
    req.data_ok    = 1'b0;
    step();
    req.valid = 1'b0;

    done = 1'b0;
    cyc  = 0;
    while (!done && cyc < 64) begin
      rdy = v.rnd ? ($urandom_range(0, 2) == 0) : (cyc >= v.ar_delay);
      arready_i = v.wr ? 1'b0 : rdy;
      awready_i = v.wr ? rdy : 1'b0;
      #1;
      av = v.wr ? awvalid_o : arvalid_o;
      chk("addr_valid", av, 1'b1);
      chk("other_addr_valid", v.wr ? arvalid_o : awvalid_o, 1'b0);
      chk("a_addr", v.wr ? awaddr_o : araddr_o, v.addr);
      chk("a_len", v.wr ? awlen_o : arlen_o, v.exp_len);
      chk("a_size", v.wr ? awsize_o : arsize_o, v.exp_size);
      chk("a_burst", v.wr ? awburst_o : arburst_o, 2'b01);
      chk("a_cache", v.wr ? awcache_o : arcache_o, v.exp_cache);
      chk("a_id", v.wr ? awid_o : arid_o, 4'd0);
      hs = av && rdy;
      step();
      if (hs) done = 1'b1;
      cyc++;
    end
    arready_i = 1'b0;
    awready_i = 1'b0;
    if (!done) chk("addr_timeout", 32'(cyc), 32'h0);

    beat = 0;
    cyc  = 0;
    hold = 0;
    while (beat < nb && cyc < 400) begin
      if (!v.rnd && beat == v.hold_at && hold < v.hold_len) begin
        dok = 1'b0;
        hold++;
      end else begin
        dok = v.rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      req.data_ok = dok;
      if (!v.wr) begin
        rvalid_i = v.rnd ? 1'($urandom) : 1'b1;
        rdata_i  = d[beat];
        rlast_i  = (beat == nb - 1);
        rresp_i  = (beat == v.rerr_beat) ? 2'b10 : 2'b00;
        if (beat == v.rst_at_beat) begin
          rvalid_i = 1'b1;
          req.data_ok = 1'b1;
          chk("err_before_rst", err, model_err);
          rst = 1'b1;
          #1;
          chk_all_idle("async_rst");
          rvalid_i = 1'b0;
          req.data_ok = 1'b0;
          step();
          rst = 1'b0;
          model_err = 1'b0;
          step();
          return;
        end
        #1;
        hs = rvalid_i && dok;
        chk("rready", rready_o, dok);
        chk("r_data_ok", resp.data_ok, hs);
        if (hs) begin
          chk("r_data", resp.r_data, d[beat]);
          chk("r_last", resp.data_last, beat == nb - 1);
          if (rresp_i != 2'b00) model_err = 1'b1;
        end
      end else begin
        wready_i       = v.rnd ? 1'($urandom) : ((cyc % 2) == 1);
        stb            = v.rnd ? 4'($urandom) : (((beat % 2) == 0) ? 4'hF : 4'h3);
        req.w_data     = d[beat];
        req.data_strobe = stb;
        req.data_last  = (beat == nb - 1) ^ (v.bad_last && beat == 0);
        #1;
        hs = wready_i && dok;
        chk("wvalid", wvalid_o, dok);
        chk("w_data_ok", resp.data_ok, hs);
        if (dok) begin
          chk("wdata", wdata_o, d[beat]);
          chk("wstrb", wstrb_o, stb);
          chk("wlast", wlast_o, beat == nb - 1);
        end
        if (hs && req.data_last != (beat == nb - 1)) model_err = 1'b1;
      end
      step();
      if (hs) beat++;
      cyc++;
    end
    rvalid_i = 1'b0;
    wready_i = 1'b0;
    req.data_ok = 1'b0;
    req.data_last = 1'b0;
    if (beat < nb) chk("data_timeout", 32'(beat), 32'(nb));

    if (v.wr) begin
      done = 1'b0;
      cyc  = 0;
      while (!done && cyc < 64) begin
        bvalid_i = v.rnd ? 1'($urandom) : (cyc >= 2);
        bresp_i  = v.berr ? 2'b10 : 2'b00;
        #1;
        chk("bready", bready_o, 1'b1);
        chk("no_accept_before_b", resp.ready, 1'b0);
        if (bvalid_i) begin
          done = 1'b1;
          if (v.berr) model_err = 1'b1;
        end
        step();
        cyc++;
      end
      bvalid_i = 1'b0;
      bresp_i  = 2'b00;
      if (!done) chk("b_timeout", 32'(cyc), 32'h0);
    end

    chk("ready_after", resp.ready, 1'b1);
    chk("err_flag", err, model_err);
  endtask

  initial begin
    vec_t v;
    rst = 1'b1;
    req = '0;
    arready_i = 1'b0; awready_i = 1'b0; wready_i = 1'b0;
    rvalid_i = 1'b0; rdata_i = '0; rlast_i = 1'b0; rresp_i = 2'b00; rid_i = 4'd5;
    bvalid_i = 1'b0; bresp_i = 2'b00;

    //            wr  addr          bs    c  ds   ard hat hln bad rnd rerr berr rst  len    size  cache
    tbl[0] = '{1'b0, 32'h1C000010, 4'd3,  1, 2'd2, 0, -1, 0, 0, 0, -1, 0, -1, 8'd3,  3'd2, 4'hF};
    tbl[1] = '{1'b0, 32'h1FE001E4, 4'd0,  0, 2'd2, 3,  0, 2, 0, 0, -1, 0, -1, 8'd0,  3'd2, 4'h0};
    tbl[2] = '{1'b0, 32'h1C000100, 4'd3,  1, 2'd2, 0,  2, 4, 0, 0, -1, 0, -1, 8'd3,  3'd2, 4'hF};
    tbl[3] = '{1'b1, 32'h1C000200, 4'd1,  1, 2'd2, 0, -1, 0, 0, 0, -1, 0, -1, 8'd1,  3'd2, 4'hF};
    tbl[4] = '{1'b1, 32'h1C000300, 4'd1,  0, 2'd2, 1, -1, 0, 1, 0, -1, 0, -1, 8'd1,  3'd2, 4'h0};
    tbl[5] = '{1'b0, 32'h1C000400, 4'd3,  1, 2'd2, 0, -1, 0, 0, 0,  0, 0,  2, 8'd3,  3'd2, 4'hF};
    tbl[6] = '{1'b0, 32'h1C000500, 4'd15, 0, 2'd1, 2, -1, 0, 0, 0, -1, 0, -1, 8'd15, 3'd1, 4'h0};
    tbl[7] = '{1'b1, 32'h1C000600, 4'd0,  1, 2'd0, 0,  0, 1, 0, 0, -1, 1, -1, 8'd0,  3'd0, 4'hF};

    @(negedge clk);
    #1;
    chk_all_idle("por");
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i]);
      if (model_err) do_reset();
    end

    // A request presented while reset is asserted must be dropped.
    req.valid = 1'b1;
    req.write = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_vs_accept_ready", resp.ready, 1'b0);
    step();
    rst = 1'b0;
    req.valid = 1'b0;
    step();
    chk("rst_vs_accept_awvalid", awvalid_o, 1'b0);
    chk("rst_vs_accept_idle", resp.ready, 1'b1);

    for (int n = 0; n < 40; n++) begin
      v = mk_rand();
      run_txn(v);
      if (model_err) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_bus_axi_bridge.md
Name: cache_bus_axi_bridge

Overview:
- Responder end of the cache bus (`cache_bus_req_t` / `cache_bus_resp_t`) driven by the icache and dcache fetch/refill FSMs.
- Accepts one address-phase request at a time and converts it to an AXI4 read or write burst (INCR, 32-bit data).
- Returns read beats and accepts write beats under the cache-bus data_ok handshake.
- Sits between the per-core bus arbiter output and the SoC AXI interconnect.

Parameters:
- ID_WIDTH, 4, width of the AXI ID fields.
- ID_VALUE, 0, constant driven on arid/awid; bid/rid are ignored.
- CACHED_ATTR, 4'b1111, ar/awcache value when req.cached=1; 4'b0000 otherwise.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- bus_req_i  in  cache_bus_req_t  fields used: valid, write, burst_size[3:0], cached, data_size[1:0], addr[31:0], data_ok, data_last, data_strobe[3:0], w_data[31:0].
- bus_resp_o  out  cache_bus_resp_t  fields driven: ready, data_ok, data_last, r_data[31:0].
- err_o  out  1  sticky protocol error flag.
- AR channel, all outputs except arready_i: arvalid_o 1, arready_i 1 (in), araddr_o 32, arlen_o 8, arsize_o 3, arburst_o 2, arcache_o 4, arid_o ID_WIDTH.
- R channel: rvalid_i 1, rready_o 1, rdata_i 32, rlast_i 1, rresp_i 2, rid_i ID_WIDTH.
- AW channel, all outputs except awready_i: awvalid_o 1, awready_i 1 (in), awaddr_o 32, awlen_o 8, awsize_o 3, awburst_o 2, awcache_o 4, awid_o ID_WIDTH.
- W channel: wvalid_o 1, wready_i 1, wdata_o 32, wstrb_o 4, wlast_o 1.
- B channel: bvalid_i 1, bready_o 1, bresp_i 2.

Behaviour:
- FSM states (one-hot): IDLE, RADDR, RDATA, WADDR, WDATA, WRESP. Reset state is IDLE.
- Reset values: all AXI valid/ready outputs 0, bus_resp_o all 0, err_o 0, beat counter 0.
- IDLE:
  - bus_resp_o.ready = 1 (combinational, IDLE only).
  - On bus_req_i.valid, latch addr, len = {4'b0, burst_size}, size = {1'b0, data_size}, cache attribute and write.
  - Next state is WADDR if write=1, else RADDR.
  - The request is accepted in that same cycle; the initiator drops valid the next cycle.
- RADDR:
  - arvalid_o = 1 with the latched fields; arburst_o = 2'b01.
  - Payload is held stable until arready_i; on arready_i go to RDATA. Earliest arvalid is 1 cycle after acceptance.
- RDATA, combinational pass-through, 0 added latency:
  - rready_o = bus_req_i.data_ok.
  - bus_resp_o.data_ok = rvalid_i & bus_req_i.data_ok.
  - r_data = rdata_i; data_last = rlast_i.
  - On the handshake with rlast_i=1, go to IDLE.
  - While bus_req_i.data_ok=0, no beat is consumed and rvalid_i is back-pressured.
- WADDR:
  - awvalid_o = 1, fields as for AR; on awready_i go to WDATA and clear the beat counter.
- WDATA:
  - wvalid_o = bus_req_i.data_ok; wdata/wstrb come from the request.
  - wlast_o = (beat counter == len). It is generated internally and never taken from bus_req_i.data_last.
  - bus_resp_o.data_ok = wready_i & bus_req_i.data_ok (beat accepted).
  - Each accepted beat increments the 8-bit counter.
  - After the beat accepted with wlast_o, go to WRESP.
- WRESP:
  - bready_o = 1; on bvalid_i go to IDLE.
  - bus_resp_o.ready stays 0 until back in IDLE, so a new request is never accepted before the B response.
- err_o is set and held until rst on any of:
  - an accepted W beat where bus_req_i.data_last != wlast_o;
  - rresp_i != 0 on an R handshake;
  - bresp_i != 0 on a B handshake.
  Data is still forwarded and the FSM still progresses.
- Boundary conditions:
  - burst_size=0 gives single-beat transfers; wlast_o is 1 on the first beat.
  - len up to 15 is supported with no counter wrap.
  - rvalid_i before bus_req_i.data_ok is held off without loss.
  - Simultaneous IDLE acceptance and reset: reset wins.
  - Reset mid-burst forces IDLE with all valids 0 immediately (async). The outstanding AXI transaction is abandoned; system-wide reset is assumed.

Decomposition:
- Into the shared bus package (next to `cache_bus_req_t` / `cache_bus_resp_t` in `lsu.svh`):
  - AXI burst/resp encodings (AXI_BURST_INCR, AXI_RESP_OKAY);
  - the bridge state typedef;
  - CACHED_ATTR defaults.
- No sub-module. The R path is pure pass-through and the W beat counter is inline.

Test Plan:
- Cached 4-beat read: req addr=0x1C000010, burst_size=3, cached=1; AXI returns 0xA0..0xA3 → arlen=3, arcache=4'b1111, arsize=2, four data_ok pulses in order, data_last with 0xA3, then ready=1 again.
- Uncached single read with back-pressure: addr=0x1FE001E4, burst_size=0; arready delayed 3 cycles; data_ok held low 2 cycles while rvalid=1 → rready=0 during the hold, exactly one data_ok with last=1, err_o=0.
- Read back-pressure mid-burst: drop bus_req_i.data_ok after beat 1 for 4 cycles → no beat lost or duplicated; r_data sequence intact.
- 2-beat write: burst_size=1, strobes 4'hF then 4'h3; wready toggles every cycle; bvalid 2 cycles after wlast → wlast only on the 2nd accepted beat, ready reasserts only after B.
- Write data_last mismatch: burst_size=1 with data_last=1 on beat 0 → err_o=1 sticky; wlast still on beat 1; FSM returns to IDLE.
- Async reset during RDATA beat 2 → all valids/readies 0 in the same cycle, state IDLE, err_o=0; next read completes normally.
